// File: rtl/axilite_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : axilite_mem_bridge_if
// Purpose  : AXI4-Lite slave channels plus req/ack memory port of the bridge.
// Revision : 1.0
// ============================================================================
interface axilite_mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [DATA_W-1:0] s_axi_wdata;
    logic [STRB_W-1:0] s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    logic              mem_w_req;
    logic              mem_w_ack;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [DATA_W-1:0] mem_w_data;
    logic [STRB_W-1:0] mem_w_strb;
    logic              mem_r_req;
    logic              mem_r_ack;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [DATA_W-1:0] mem_r_data;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output mem_w_req, mem_w_addr, mem_w_data, mem_w_strb, mem_r_req, mem_r_addr,
        input  mem_w_ack, mem_r_ack, mem_r_data
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  mem_w_req, mem_w_addr, mem_w_data, mem_w_strb, mem_r_req, mem_r_addr,
        output mem_w_ack, mem_r_ack, mem_r_data
    );
endinterface
`default_nettype wire

// File: rtl/axilite_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axilite_mem_bridge
// Purpose  : AXI4-Lite slave to req/ack memory port with window decode (DECERR).
//            Optional ack timeout (SLVERR) enabled by AXIL_BRIDGE_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module axilite_mem_bridge #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 64,
    parameter logic [ADDR_W-1:0] MEM_ADDR_START = 'h1000_0000,
    parameter logic [ADDR_W-1:0] MEM_ADDR_RANGE = 'h1000,
    parameter int                TIMEOUT_CYC    = 256
) (
    input wire logic aclk,
    input wire logic areset,
    axilite_mem_bridge_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;
    // One extra bit so START+RANGE-1 cannot wrap at the top of the address space
    localparam logic [ADDR_W:0] c_WIN_LO = {1'b0, MEM_ADDR_START};
    localparam logic [ADDR_W:0] c_WIN_HI = {1'b0, MEM_ADDR_START} + {1'b0, MEM_ADDR_RANGE}
                                           - (ADDR_W+1)'(1);

    localparam logic [1:0] W_IDLE = 2'd0, W_MEM = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_MEM = 2'd1, R_RESP = 2'd2;

    function automatic logic f_in_window(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= c_WIN_LO) && ({1'b0, a} <= c_WIN_HI);
    endfunction

    logic [1:0]        r_wstate, w_wstate_nxt, r_rstate, w_rstate_nxt;
    logic              r_aw_full, r_w_full, w_aw_full_nxt, w_w_full_nxt;
    logic [ADDR_W-1:0] r_awaddr, w_awaddr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [STRB_W-1:0] r_wstrb, w_wstrb_nxt;
    logic              r_awready, r_wready, r_bvalid, w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
    logic [1:0]        r_bresp, w_bresp_nxt, r_rresp, w_rresp_nxt;
    logic              r_mem_w_req, w_mwreq_nxt, r_mem_r_req, w_mrreq_nxt;
    logic [ADDR_W-1:0] r_mem_w_addr, w_mwaddr_nxt, r_mem_r_addr, w_mraddr_nxt;
    logic [DATA_W-1:0] r_mem_w_data, w_mwdata_nxt, r_rdata, w_rdata_nxt;
    logic [STRB_W-1:0] r_mem_w_strb, w_mwstrb_nxt;
    logic              r_arready, r_rvalid, w_arready_nxt, w_rvalid_nxt;
    logic              w_w_timeout, w_r_timeout;

    // A beat arriving this cycle counts as held, so AW+W together dispatch at once
    wire logic              w_aw_hs   = bus.s_axi_awvalid & r_awready;
    wire logic              w_w_hs    = bus.s_axi_wvalid & r_wready;
    wire logic              w_aw_have = r_aw_full | w_aw_hs;
    wire logic              w_w_have  = r_w_full | w_w_hs;
    wire logic [ADDR_W-1:0] w_waddr   = r_aw_full ? r_awaddr : bus.s_axi_awaddr;
    wire logic [DATA_W-1:0] w_wdata   = r_w_full ? r_wdata : bus.s_axi_wdata;
    wire logic [STRB_W-1:0] w_wstrb   = r_w_full ? r_wstrb : bus.s_axi_wstrb;
    wire logic              w_w_inwin = f_in_window(w_waddr);
    wire logic              w_ar_hs   = bus.s_axi_arvalid & r_arready;
    wire logic              w_r_inwin = f_in_window(bus.s_axi_araddr);

`ifdef AXIL_BRIDGE_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);
    logic [c_TO_W-1:0] r_wto_cnt, r_rto_cnt;

    // Counters sit at zero outside *_MEM, so every entry starts a fresh count
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wto_cnt <= '0;
            r_rto_cnt <= '0;
        end else begin
            r_wto_cnt <= (r_wstate == W_MEM) ? r_wto_cnt + 1'b1 : '0;
            r_rto_cnt <= (r_rstate == R_MEM) ? r_rto_cnt + 1'b1 : '0;
        end
    end

    assign w_w_timeout = (r_wstate == W_MEM) && (r_wto_cnt == c_TO_LAST) && !bus.mem_w_ack;
    assign w_r_timeout = (r_rstate == R_MEM) && (r_rto_cnt == c_TO_LAST) && !bus.mem_r_ack;
`else
    assign w_w_timeout = 1'b0;
    assign w_r_timeout = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: if (w_aw_have && w_w_have) w_wstate_nxt = w_w_inwin ? W_MEM : W_RESP;
            W_MEM:  if (bus.mem_w_ack || w_w_timeout) w_wstate_nxt = W_RESP;
            W_RESP: if (r_bvalid && bus.s_axi_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: if (w_ar_hs) w_rstate_nxt = w_r_inwin ? R_MEM : R_RESP;
            R_MEM:  if (bus.mem_r_ack || w_r_timeout) w_rstate_nxt = R_RESP;
            R_RESP: if (r_rvalid && bus.s_axi_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_aw_full_nxt = r_aw_full;
        w_w_full_nxt  = r_w_full;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_mwreq_nxt   = r_mem_w_req;
        w_mwaddr_nxt  = r_mem_w_addr;
        w_mwdata_nxt  = r_mem_w_data;
        w_mwstrb_nxt  = r_mem_w_strb;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_aw_full_nxt = 1'b1;
                    w_awaddr_nxt  = bus.s_axi_awaddr;
                end
                if (w_w_hs) begin
                    w_w_full_nxt = 1'b1;
                    w_wdata_nxt  = bus.s_axi_wdata;
                    w_wstrb_nxt  = bus.s_axi_wstrb;
                end
                if (w_aw_have && w_w_have) begin
                    if (w_w_inwin) begin
                        w_mwreq_nxt  = 1'b1;
                        w_mwaddr_nxt = w_waddr - MEM_ADDR_START;
                        w_mwdata_nxt = w_wdata;
                        w_mwstrb_nxt = w_wstrb;
                    end else begin
                        w_bvalid_nxt = 1'b1;
                        w_bresp_nxt  = c_RESP_DECERR;
                    end
                end
            end
            W_MEM: begin
                if (bus.mem_w_ack || w_w_timeout) begin
                    w_mwreq_nxt  = 1'b0;
                    w_bvalid_nxt = 1'b1;
                    w_bresp_nxt  = bus.mem_w_ack ? c_RESP_OKAY : c_RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (r_bvalid && bus.s_axi_bready) begin
                    w_bvalid_nxt  = 1'b0;
                    w_aw_full_nxt = 1'b0;
                    w_w_full_nxt  = 1'b0;
                end
            end
            default: ;
        endcase
        w_awready_nxt = (w_wstate_nxt == W_IDLE) && !w_aw_full_nxt;
        w_wready_nxt  = (w_wstate_nxt == W_IDLE) && !w_w_full_nxt;

        w_rvalid_nxt = r_rvalid;
        w_rresp_nxt  = r_rresp;
        w_rdata_nxt  = r_rdata;
        w_mrreq_nxt  = r_mem_r_req;
        w_mraddr_nxt = r_mem_r_addr;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    if (w_r_inwin) begin
                        w_mrreq_nxt  = 1'b1;
                        w_mraddr_nxt = bus.s_axi_araddr - MEM_ADDR_START;
                    end else begin
                        w_rvalid_nxt = 1'b1;
                        w_rresp_nxt  = c_RESP_DECERR;
                        w_rdata_nxt  = '0;
                    end
                end
            end
            R_MEM: begin
                if (bus.mem_r_ack || w_r_timeout) begin
                    w_mrreq_nxt  = 1'b0;
                    w_rvalid_nxt = 1'b1;
                    w_rresp_nxt  = bus.mem_r_ack ? c_RESP_OKAY : c_RESP_SLVERR;
                    w_rdata_nxt  = bus.mem_r_ack ? bus.mem_r_data : '0;
                end
            end
            R_RESP: if (r_rvalid && bus.s_axi_rready) w_rvalid_nxt = 1'b0;
            default: ;
        endcase
        w_arready_nxt = (w_rstate_nxt == R_IDLE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_aw_full <= 1'b0;  r_w_full <= 1'b0;
            r_awaddr <= '0;     r_wdata <= '0;      r_wstrb <= '0;
            r_awready <= 1'b0;  r_wready <= 1'b0;   r_bvalid <= 1'b0;  r_bresp <= '0;
            r_mem_w_req <= 1'b0; r_mem_w_addr <= '0; r_mem_w_data <= '0; r_mem_w_strb <= '0;
            r_arready <= 1'b0;  r_rvalid <= 1'b0;   r_rresp <= '0;     r_rdata <= '0;
            r_mem_r_req <= 1'b0; r_mem_r_addr <= '0;
        end else begin
            r_aw_full <= w_aw_full_nxt;  r_w_full <= w_w_full_nxt;
            r_awaddr <= w_awaddr_nxt;    r_wdata <= w_wdata_nxt;    r_wstrb <= w_wstrb_nxt;
            r_awready <= w_awready_nxt;  r_wready <= w_wready_nxt;
            r_bvalid <= w_bvalid_nxt;    r_bresp <= w_bresp_nxt;
            r_mem_w_req <= w_mwreq_nxt;  r_mem_w_addr <= w_mwaddr_nxt;
            r_mem_w_data <= w_mwdata_nxt; r_mem_w_strb <= w_mwstrb_nxt;
            r_arready <= w_arready_nxt;  r_rvalid <= w_rvalid_nxt;
            r_rresp <= w_rresp_nxt;      r_rdata <= w_rdata_nxt;
            r_mem_r_req <= w_mrreq_nxt;  r_mem_r_addr <= w_mraddr_nxt;
        end
    end

    assign bus.s_axi_awready = r_awready;
    assign bus.s_axi_wready  = r_wready;
    assign bus.s_axi_bvalid  = r_bvalid;
    assign bus.s_axi_bresp   = r_bresp;
    assign bus.s_axi_arready = r_arready;
    assign bus.s_axi_rvalid  = r_rvalid;
    assign bus.s_axi_rresp   = r_rresp;
    assign bus.s_axi_rdata   = r_rdata;
    assign bus.mem_w_req     = r_mem_w_req;
    assign bus.mem_w_addr    = r_mem_w_addr;
    assign bus.mem_w_data    = r_mem_w_data;
    assign bus.mem_w_strb    = r_mem_w_strb;
    assign bus.mem_r_req     = r_mem_r_req;
    assign bus.mem_r_addr    = r_mem_r_addr;
endmodule
`default_nettype wire
